// File: rtl/key_input_ctrl_if.sv
// -----------------------------------------------------------------------------
// key_input_ctrl_if
//
// Purpose:
//   Bundles the button-side and CPU-side signals of key_input_ctrl so they
//   travel as one port. The clock and reset are kept outside the interface.
//
// Signals:
//   keys        [3:0] raw push-buttons, active-low, asynchronous to the clock
//   rd_strobe         one-cycle pulse per completed CPU read of $00ff
//   key_out     [7:0] ASCII direction code presented to the CPU
//   fifo_count  [2:0] queued, unconsumed presses (0..4)
//   overflow          sticky flag, a press was dropped
//   press_count [7:0] accepted presses, modulo 256
//
// Modports:
//   master : the side that drives buttons and reads the code (CPU / bench)
//   slave  : key_input_ctrl itself
// -----------------------------------------------------------------------------
interface key_input_ctrl_if;
    logic [3:0] keys;
    logic       rd_strobe;
    logic [7:0] key_out;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] press_count;

    modport master (
        output keys,
        output rd_strobe,
        input  key_out,
        input  fifo_count,
        input  overflow,
        input  press_count
    );

    modport slave (
        input  keys,
        input  rd_strobe,
        output key_out,
        output fifo_count,
        output overflow,
        output press_count
    );
endinterface

// File: rtl/key_input_ctrl.sv
// -----------------------------------------------------------------------------
// key_input_ctrl
//
// Purpose:
//   Debounces four raw active-low push-buttons and turns each accepted press
//   into an ASCII direction code for the game program. The code is what the
//   CPU sees when it reads $00ff. Presses can be queued in a 4-entry FIFO so
//   that fast taps between two CPU polls are not lost.
//
//   Key map: keys[0] 'd' (8'h64), keys[1] 's' (8'h73),
//            keys[2] 'w' (8'h77), keys[3] 'a' (8'h61)
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing samples needed to accept a level
//                    change (1..255), default 16
//   RESET_KEY        key_out value after reset, default 8'h73 ('s')
//
// Ports:
//   clock    CPU clock, all state updates on the rising edge
//   nreset   synchronous, active-low reset
//   bus      key_input_ctrl_if.slave (keys, rd_strobe, key_out,
//            fifo_count, overflow, press_count)
//
// Build option:
//   KEY_INPUT_FIFO_EN  defined   : 4-entry press FIFO, fifo_count and
//                                  overflow are live, rd_strobe pops.
//                      undefined : no FIFO, each serviced press overwrites
//                                  last_key, fifo_count/overflow tied to 0,
//                                  rd_strobe ignored.
// -----------------------------------------------------------------------------
module key_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [7:0]  RESET_KEY       = 8'h73
) (
    input  logic             clock,
    input  logic             nreset,
    key_input_ctrl_if.slave  bus
);

    // Counter value at which the next differing sample is the accepting one.
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    function automatic logic [7:0] key_code(input logic [1:0] idx);
        logic [7:0] code;
        case (idx)
            2'd0:    code = 8'h64;   // 'd'
            2'd1:    code = 8'h73;   // 's'
            2'd2:    code = 8'h77;   // 'w'
            default: code = 8'h61;   // 'a'
        endcase
        return code;
    endfunction

    function automatic logic [7:0] popcount4(input logic [3:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + 8'(v[i]);
        end
        return n;
    endfunction

    // -------------------------------------------------------------------------
    // Synchronizer, debounce and press detection
    // -------------------------------------------------------------------------
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] stable_q, stable_d;
    // One-cycle delayed copy of stable; a 1->0 step between the two is a press.
    logic [3:0] stable_dly_q;
    logic [7:0] db_cnt_q [4];
    logic [7:0] db_cnt_d [4];
    logic [3:0] pend_q, pend_d;
    logic [7:0] press_count_q, press_count_d;
    logic [3:0] press;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            stable_d[k] = stable_q[k];
            db_cnt_d[k] = 8'd0;
            if (sync2_q[k] != stable_q[k]) begin
                if (db_cnt_q[k] == DB_LAST) begin
                    stable_d[k] = sync2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 8'd1;
                end
            end
        end
    end

    assign press = stable_dly_q & ~stable_q;

    // -------------------------------------------------------------------------
    // Service: one pending key per cycle, lowest index first
    // -------------------------------------------------------------------------
    logic       svc_vld;
    logic [1:0] svc_idx;
    logic [3:0] svc_mask;

    always_comb begin
        svc_vld = 1'b0;
        svc_idx = 2'd0;
        // Descending scan so the lowest set index is the one that sticks.
        for (int k = 3; k >= 0; k--) begin
            if (pend_q[k]) begin
                svc_vld = 1'b1;
                svc_idx = 2'(k);
            end
        end
    end

    assign svc_mask = svc_vld ? (4'b0001 << svc_idx) : 4'b0000;

    // A press on a key that is pending and not serviced this cycle simply
    // merges into the existing bit.
    assign pend_d        = (pend_q & ~svc_mask) | press;
    assign press_count_d = press_count_q + popcount4(press);

    always_ff @(posedge clock) begin
        if (!nreset) begin
            sync1_q       <= 4'b1111;
            sync2_q       <= 4'b1111;
            stable_q      <= 4'b1111;
            stable_dly_q  <= 4'b1111;
            pend_q        <= 4'b0000;
            press_count_q <= 8'd0;
            for (int k = 0; k < 4; k++) begin
                db_cnt_q[k] <= 8'd0;
            end
        end else begin
            sync1_q       <= bus.keys;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_dly_q  <= stable_q;
            pend_q        <= pend_d;
            press_count_q <= press_count_d;
            for (int k = 0; k < 4; k++) begin
                db_cnt_q[k] <= db_cnt_d[k];
            end
        end
    end

    assign bus.press_count = press_count_q;

`ifdef KEY_INPUT_FIFO_EN
    // -------------------------------------------------------------------------
    // 4-entry circular press FIFO
    // -------------------------------------------------------------------------
    logic [7:0] mem_q [4];
    logic [1:0] rptr_q, rptr_d;
    logic [1:0] wptr_q, wptr_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic [7:0] last_key_q, last_key_d;
    logic       ovf_q, ovf_d;
    logic       pop, push, drop;

    assign pop  = bus.rd_strobe && (fcnt_q != 3'd0);
    // A pop in the same cycle frees the head slot, so a full FIFO still
    // accepts; with wptr == rptr the new entry lands in that freed slot.
    assign push = svc_vld && ((fcnt_q != 3'd4) || pop);
    assign drop = svc_vld && !push;

    always_comb begin
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        last_key_d = last_key_q;
        ovf_d      = ovf_q | drop;
        fcnt_d     = fcnt_q + {2'b00, push} - {2'b00, pop};
        if (pop) begin
            // The CPU already sampled the head, so it becomes the idle value.
            last_key_d = mem_q[rptr_q];
            rptr_d     = rptr_q + 2'd1;
        end
        if (push) begin
            wptr_d = wptr_q + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            rptr_q     <= 2'd0;
            wptr_q     <= 2'd0;
            fcnt_q     <= 3'd0;
            last_key_q <= RESET_KEY;
            ovf_q      <= 1'b0;
        end else begin
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            fcnt_q     <= fcnt_d;
            last_key_q <= last_key_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: the count and pointers decide what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wptr_q] <= key_code(svc_idx);
        end
    end

    assign bus.key_out    = (fcnt_q != 3'd0) ? mem_q[rptr_q] : last_key_q;
    assign bus.fifo_count = fcnt_q;
    assign bus.overflow   = ovf_q;
`else
    // -------------------------------------------------------------------------
    // No FIFO: newest serviced press overwrites the presented code
    // -------------------------------------------------------------------------
    logic [7:0] last_key_q, last_key_d;
    logic       unused_rd_strobe;

    assign unused_rd_strobe = bus.rd_strobe;
    assign last_key_d       = svc_vld ? key_code(svc_idx) : last_key_q;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            last_key_q <= RESET_KEY;
        end else begin
            last_key_q <= last_key_d;
        end
    end

    assign bus.key_out    = last_key_q;
    assign bus.fifo_count = 3'd0;
    assign bus.overflow   = 1'b0;
`endif

endmodule
